// File: rtl/bus_arbiter_rr.sv
// Round-robin shared-bus arbiter with per-(dest,src) backpressure, per-source holdoff and a
// registered broadcast pipeline. Define BUS_ARB_STALL_CNT_EN to add the stall_cnt port.
module bus_arbiter_rr #(
   parameter int unsigned NUM_PE       = 8,
   parameter int unsigned DATA_LEN     = 16,
   parameter int unsigned BUS_ADDR_LEN = $clog2(NUM_PE),
   parameter int unsigned NUM_STAGES   = 3,
   parameter int unsigned FULL_LAT     = 2 * NUM_STAGES
`ifdef BUS_ARB_STALL_CNT_EN
   ,
   parameter int unsigned STALL_CNT_W  = 32
`endif
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_PE-1:0]                req_valid,
   input  logic [BUS_ADDR_LEN*NUM_PE-1:0]   req_dest_i,
   input  logic [DATA_LEN*NUM_PE-1:0]       req_data_i,
   output logic [NUM_PE-1:0]                req_ready,
   input  logic [NUM_PE*NUM_PE-1:0]         rd_buffer_full_i,
   output logic                             bus_valid,
   output logic [DATA_LEN-1:0]              data_bus,
   output logic [BUS_ADDR_LEN-1:0]          addr_bus,
   output logic [NUM_PE-1:0]                rd_from_bus
`ifdef BUS_ARB_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0]           stall_cnt
`endif
);

   localparam int unsigned HoldW = (FULL_LAT > 0) ? $clog2(FULL_LAT + 1) : 1;
   localparam logic [HoldW-1:0] HoldInit = HoldW'(FULL_LAT);

   typedef struct packed {
      logic                    valid;
      logic [DATA_LEN-1:0]     data;
      logic [BUS_ADDR_LEN-1:0] src;
      logic [NUM_PE-1:0]       rd;
   } beat_t;

   logic [BUS_ADDR_LEN-1:0] ptr_q, ptr_d;
   logic [HoldW-1:0]        hold_q [NUM_PE];
   logic [HoldW-1:0]        hold_d [NUM_PE];
   beat_t                   pipe_q [NUM_STAGES];
   beat_t                   pipe_d [NUM_STAGES];

   logic [BUS_ADDR_LEN-1:0] dest_s [NUM_PE];
   logic [NUM_PE-1:0]       eligible;
   logic                    found;
   logic                    do_grant;
   logic [BUS_ADDR_LEN-1:0] gnt_src;

   // Out-of-range destinations have no full flag and are never eligible.
   always_comb begin
      for (int unsigned s = 0; s < NUM_PE; s++) begin
         dest_s[s]   = req_dest_i[s*BUS_ADDR_LEN +: BUS_ADDR_LEN];
         eligible[s] = 1'b0;
         if (req_valid[s] && (hold_q[s] == '0) && (32'(dest_s[s]) < NUM_PE)) begin
            eligible[s] = !rd_buffer_full_i[32'(dest_s[s])*NUM_PE + s];
         end
      end
   end

   always_comb begin
      found   = 1'b0;
      gnt_src = '0;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
         if (!found && eligible[(32'(ptr_q) + i) % NUM_PE]) begin
            found   = 1'b1;
            gnt_src = BUS_ADDR_LEN'((32'(ptr_q) + i) % NUM_PE);
         end
      end
      // Grant is masked while reset is asserted so req_ready reads 0 during reset.
      do_grant  = found & rstn;
      req_ready = '0;
      if (do_grant) begin
         req_ready[gnt_src] = 1'b1;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (do_grant) begin
         ptr_d = BUS_ADDR_LEN'((32'(gnt_src) + 1) % NUM_PE);
      end
      for (int unsigned s = 0; s < NUM_PE; s++) begin
         if (req_ready[s]) begin
            hold_d[s] = HoldInit;
         end else if (hold_q[s] != '0) begin
            hold_d[s] = hold_q[s] - 1'b1;
         end else begin
            hold_d[s] = '0;
         end
      end
      pipe_d[0] = '0;
      if (do_grant) begin
         pipe_d[0].valid = 1'b1;
         pipe_d[0].data  = req_data_i[32'(gnt_src)*DATA_LEN +: DATA_LEN];
         pipe_d[0].src   = gnt_src;
         pipe_d[0].rd    = NUM_PE'(1) << dest_s[gnt_src];
      end
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr_q  <= '0;
         hold_q <= '{default: '0};
         pipe_q <= '{default: '0};
      end else begin
         ptr_q  <= ptr_d;
         hold_q <= hold_d;
         pipe_q <= pipe_d;
      end
   end

   // Invalid beats are zeroed at entry, so the last stage drives the bus directly.
   assign bus_valid   = pipe_q[NUM_STAGES-1].valid;
   assign data_bus    = pipe_q[NUM_STAGES-1].data;
   assign addr_bus    = pipe_q[NUM_STAGES-1].src;
   assign rd_from_bus = pipe_q[NUM_STAGES-1].rd;

`ifdef BUS_ARB_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((|req_valid) && !(|req_ready) && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: directed table, corner sequences and randomized
// traffic against a cycle-stamp reference model.
module tb_bus_arbiter_rr;

   localparam int NP = 8;
   localparam int DL = 16;
   localparam int AW = 3;
   localparam int NS = 3;
   localparam int FL = 6;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]    req_valid = '0;
   logic [AW*NP-1:0] req_dest_i = '0;
   logic [DL*NP-1:0] req_data_i = '0;
   logic [NP*NP-1:0] full = '0;
   logic [NP-1:0]    req_ready;
   logic             bus_valid;
   logic [DL-1:0]    data_bus;
   logic [AW-1:0]    addr_bus;
   logic [NP-1:0]    rd_from_bus;
`ifdef BUS_ARB_STALL_CNT_EN
   logic [31:0]      stall_cnt;
   logic [NP-1:0]    ready4;
   logic             bv4;
   logic [DL-1:0]    db4;
   logic [AW-1:0]    ab4;
   logic [NP-1:0]    rd4;
   logic [3:0]       stall4;
`endif

   bus_arbiter_rr u_dut (
      .clk              (clk),
      .rstn             (rstn),
      .req_valid        (req_valid),
      .req_dest_i       (req_dest_i),
      .req_data_i       (req_data_i),
      .req_ready        (req_ready),
      .rd_buffer_full_i (full),
      .bus_valid        (bus_valid),
      .data_bus         (data_bus),
      .addr_bus         (addr_bus),
      .rd_from_bus      (rd_from_bus)
`ifdef BUS_ARB_STALL_CNT_EN
      ,
      .stall_cnt        (stall_cnt)
`endif
   );

`ifdef BUS_ARB_STALL_CNT_EN
   bus_arbiter_rr #(.STALL_CNT_W(4)) u_dut4 (
      .clk              (clk),
      .rstn             (rstn),
      .req_valid        (req_valid),
      .req_dest_i       (req_dest_i),
      .req_data_i       (req_data_i),
      .req_ready        (ready4),
      .rd_buffer_full_i (full),
      .bus_valid        (bv4),
      .data_bus         (db4),
      .addr_bus         (ab4),
      .rd_from_bus      (rd4),
      .stall_cnt        (stall4)
   );
`endif

   // Reference model: grant eligibility from the cycle of each source's last grant,
   // bus output from a queue of beats stamped with the cycle they are due.
   typedef struct {
      int          due;
      logic [DL-1:0] data;
      int          src;
      int          dest;
   } beat_t;

   int    cyc = 0;
   int    ptr_m = 0;
   int    last_g [NP];
   beat_t pend [$];
   int    g_last = -1;
   int    n_vec = 0;
   int    n_bad = 0;

   typedef struct {
      logic [NP-1:0]    valid;
      int               dest;
      logic [DL-1:0]    data;
      logic [NP*NP-1:0] full;
      logic [NP-1:0]    er;
      logic [27:0]      eb;
   } vec_t;

   vec_t tbl [11];

   function automatic vec_t mkv(input logic [NP-1:0] v, input int d, input logic [DL-1:0] dt,
                                input logic [NP*NP-1:0] f, input logic [NP-1:0] er,
                                input logic [27:0] eb);
      vec_t r;
      r.valid = v; r.dest = d; r.data = dt; r.full = f; r.er = er; r.eb = eb;
      return r;
   endfunction

   function automatic int exp_grant();
      for (int i = 0; i < NP; i++) begin
         int s;
         int d;
         s = (ptr_m + i) % NP;
         d = int'(req_dest_i[s*AW +: AW]);
         if (req_valid[s] && (cyc - last_g[s] > FL) && d < NP && !full[d*NP + s]) return s;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      ptr_m = 0;
      for (int s = 0; s < NP; s++) last_g[s] = -1000;
      pend.delete();
   endtask

   task automatic settle();
      int g;
      logic [27:0] eb;
      #3;
      g = exp_grant();
      chk("req_ready", req_ready, (g >= 0) ? (64'(1) << g) : 64'd0);
      eb = '0;
      if (pend.size() > 0 && pend[0].due == cyc)
         eb = {1'b1, pend[0].data, 3'(pend[0].src), 8'(1 << pend[0].dest)};
      chk("bus", {bus_valid, data_bus, addr_bus, rd_from_bus}, eb);
   endtask

   task automatic adv();
      int g;
      beat_t b;
      g = exp_grant();
      @(posedge clk);
      if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
      if (g >= 0) begin
         ptr_m = (g + 1) % NP;
         last_g[g] = cyc;
         b.due = cyc + NS;
         b.data = req_data_i[g*DL +: DL];
         b.src = g;
         b.dest = int'(req_dest_i[g*AW +: AW]);
         pend.push_back(b);
      end
      g_last = g;
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_bus", {bus_valid, data_bus, addr_bus, rd_from_bus}, 0);
      repeat (2) @(posedge clk);
      cyc += 2;
      #1;
      rstn = 1'b1;
      model_reset();
   endtask

   task automatic set_all(input logic [NP-1:0] v, input int d, input logic [DL-1:0] dt);
      req_valid = v;
      for (int s = 0; s < NP; s++) begin
         req_dest_i[s*AW +: AW] = 3'(d);
         req_data_i[s*DL +: DL] = dt;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         settle();
         adv();
      end
   endtask

   initial begin
      int gc [NP];
      logic [NP*NP-1:0] f25;
      f25 = '0;
      f25[3*NP+1] = 1'b1;

      // Single beat to dest 5, then a blocked pair flag released after one cycle.
      tbl[0]  = mkv(8'h04, 5, 16'h1234, '0, 8'h04, 28'h0);
      tbl[1]  = mkv(8'h00, 0, 16'h0000, '0, 8'h00, 28'h0);
      tbl[2]  = mkv(8'h00, 0, 16'h0000, '0, 8'h00, 28'h0);
      tbl[3]  = mkv(8'h00, 0, 16'h0000, '0, 8'h00, {1'b1, 16'h1234, 3'd2, 8'h20});
      tbl[4]  = mkv(8'h00, 0, 16'h0000, '0, 8'h00, 28'h0);
      tbl[5]  = mkv(8'h03, 3, 16'hA5A5, f25, 8'h01, 28'h0);
      tbl[6]  = mkv(8'h02, 3, 16'hA5A5, f25, 8'h00, 28'h0);
      tbl[7]  = mkv(8'h02, 3, 16'hA5A5, '0, 8'h02, 28'h0);
      tbl[8]  = mkv(8'h00, 3, 16'hA5A5, '0, 8'h00, {1'b1, 16'hA5A5, 3'd0, 8'h08});
      tbl[9]  = mkv(8'h00, 3, 16'hA5A5, '0, 8'h00, 28'h0);
      tbl[10] = mkv(8'h00, 3, 16'hA5A5, '0, 8'h00, {1'b1, 16'hA5A5, 3'd1, 8'h08});

      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      for (int i = 0; i < 11; i++) begin
         set_all(tbl[i].valid, tbl[i].dest, tbl[i].data);
         full = tbl[i].full;
         settle();
         chk("tbl_ready", req_ready, tbl[i].er);
         chk("tbl_bus", {bus_valid, data_bus, addr_bus, rd_from_bus}, tbl[i].eb);
         adv();
      end

      // Lone continuous requester: one grant every FL+1 cycles.
      set_all(8'h10, 0, 16'h4444);
      for (int k = 0; k < 15; k++) begin
         settle();
         chk("lone_ready", req_ready, (k % (FL + 1) == 0) ? 8'h10 : 8'h00);
         adv();
      end
      req_valid = '0;
      drain(4);

      // All sources requesting: strict rotation, two grants each over 16 cycles.
      do_reset();
      for (int s = 0; s < NP; s++) gc[s] = 0;
      set_all(8'hFF, 0, 16'h2222);
      for (int k = 0; k < 16; k++) begin
         settle();
         chk("rr_order", req_ready, 64'(1) << (k % NP));
         for (int s = 0; s < NP; s++) if (req_ready[s]) gc[s]++;
         adv();
      end
      for (int s = 0; s < NP; s++) chk("rr_count", gc[s], 2);
      req_valid = '0;
      drain(4);

      // Reset one cycle after a grant discards the beat; first grant goes to lowest id.
      do_reset();
      set_all(8'h40, 1, 16'h6666);
      settle();
      chk("rst_mid_grant", req_ready, 8'h40);
      adv();
      req_valid = 8'h64;
      do_reset();
      settle();
      chk("rst_first", req_ready, 8'h04);
      adv();
      req_valid = '0;
      for (int k = 0; k < 6; k++) begin
         settle();
         chk("rst_no_stale", addr_bus == 3'd6 && bus_valid, 0);
         adv();
      end

`ifdef BUS_ARB_STALL_CNT_EN
      do_reset();
      set_all(8'h02, 3, 16'h1111);
      full = f25;
      drain(10);
      chk("stall_10", stall_cnt, 10);
      chk("stall4_10", stall4, 10);
      drain(10);
      chk("stall_20", stall_cnt, 20);
      chk("stall4_sat", stall4, 4'hF);
      full = '0;
      req_valid = '0;
      drain(4);
`endif

      // Randomized traffic honouring the hold-until-granted contract.
      do_reset();
      req_valid = '0;
      for (int n = 0; n < 2000; n++) begin
         if (n == 1000) do_reset();
         settle();
         adv();
         for (int s = 0; s < NP; s++) begin
            if (g_last == s || !req_valid[s]) begin
               req_valid[s] = ($urandom_range(0, 9) < 6);
               req_dest_i[s*AW +: AW] = 3'($urandom_range(0, NP - 1));
               req_data_i[s*DL +: DL] = 16'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
               req_valid[s] = 1'b0;
            end
         end
         for (int b = 0; b < NP * NP; b++) full[b] = ($urandom_range(0, 15) == 0);
      end
      req_valid = '0;
      full = '0;
      drain(NS + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
